kb_uart_rx: RTL and testbench

- Serial receiver for the keyboard input path.
- Deserialises the asynchronous 8N1 UART line from the host and presents each received character as a 7-bit ASCII value with a one-cycle write strobe.
- Sits directly upstream of the keyboard FIFO: `rx_data` drives the FIFO's `write_data`, `rx_write` drives its `write`, and the FIFO's `buf_full` feeds back for overrun reporting.

---
 rtl/kb_uart_rx.sv | 147 ++++++++++++++
 tb/tb_kb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/kb_uart_rx.sv
// kb_uart_rx: 8N1 UART receiver presenting 7-bit characters to the keyboard FIFO.
// Define KB_UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module kb_uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       buf_full,
    output logic [6:0] rx_data,
    output logic       rx_write,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef KB_UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_sync;
    logic [DW-1:0] r_div;
    logic [3:0]    r_tcnt;
    logic [2:0]    r_bidx;
    logic [7:0]    r_shift;
    logic          w_rxs;
    logic          w_tick;
    logic          w_mid;
    logic          w_bit_end;
    logic          w_shift_en;
    logic          w_write;
    logic          w_ferr;
    logic          w_par_bad;

    assign w_rxs     = r_sync[1];
    assign w_tick    = r_div == DW'(DIV - 1);
    assign w_mid     = w_tick && r_tcnt == 4'd7;
    assign w_bit_end = w_tick && r_tcnt == 4'd15;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Counters are held at zero in IDLE so sampling is phase-aligned to the start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_tcnt  <= '0;
            r_bidx  <= '0;
            r_shift <= '0;
        end else begin
            r_div  <= (r_state == S_IDLE || w_tick) ? '0 : r_div + DW'(1);
            r_tcnt <= (r_state == S_IDLE || (r_state == S_START && w_mid)) ? '0 : r_tcnt + 4'(w_tick);
            r_bidx <= (r_state == S_IDLE) ? '0 : r_bidx + 3'(w_shift_en);
            if (w_shift_en) r_shift <= {w_rxs, r_shift[7:1]};
        end
    end

`ifdef KB_UART_RX_PARITY_EN
    logic r_par_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bad <= 1'b0;
        end else if (r_state == S_PARITY && w_bit_end) begin
            r_par_bad <= ^{r_shift, w_rxs};
        end
    end

    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_write    = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_IDLE:  w_next = w_rxs ? S_IDLE : S_START;
            S_START: w_next = !w_mid ? S_START : (w_rxs ? S_IDLE : S_DATA);
            S_DATA: begin
                w_shift_en = w_bit_end;
`ifdef KB_UART_RX_PARITY_EN
                if (w_bit_end && r_bidx == 3'd7) w_next = S_PARITY;
`else
                if (w_bit_end && r_bidx == 3'd7) w_next = S_STOP;
`endif
            end
`ifdef KB_UART_RX_PARITY_EN
            S_PARITY: w_next = w_bit_end ? S_STOP : S_PARITY;
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_write = w_rxs && !w_par_bad;
                    w_ferr  = !w_rxs || w_par_bad;
                    w_next  = w_rxs ? S_IDLE : S_BREAK;
                end
            end
            // A line held low must return high before a new start edge is accepted.
            S_BREAK: w_next = w_rxs ? S_IDLE : S_BREAK;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_write  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_data   <= w_write ? r_shift[6:0] : rx_data;
            rx_write  <= w_write;
            frame_err <= w_ferr;
            overrun   <= w_write && buf_full;
            rx_busy   <= w_next != S_IDLE;
        end
    end
endmodule

// File: tb/tb_kb_uart_rx.sv
// tb_kb_uart_rx: directed frames against a frame-level event model of kb_uart_rx.
module tb_kb_uart_rx;
    localparam int DIV = 1;
`ifdef KB_UART_RX_PARITY_EN
    localparam int NBITS   = 10;
    localparam int LAT_LIT = 171;
    localparam int GAP_LIT = 176;
`else
    localparam int NBITS   = 9;
    localparam int LAT_LIT = 155;
    localparam int GAP_LIT = 160;
`endif
    localparam int LAT = 2 + DIV * (8 + 16 * NBITS) + 1;

    typedef struct {
        int         cyc;
        logic       wr;
        logic [6:0] data;
        logic       ovr;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       buf_full;
    logic [6:0] rx_data;
    logic       rx_write;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_write = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         last_wr_cyc = 0;
    int         prev_wr_cyc = 0;
    logic [6:0] last_wr_data = '0;
    logic [6:0] prev_wr_data = '0;
    logic [6:0] m_data = '0;
    ev_t        q[$];

    kb_uart_rx #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .buf_full(buf_full),
        .rx_data(rx_data), .rx_write(rx_write), .frame_err(frame_err),
        .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t        e;
        logic [9:0] got;
        logic [9:0] want;
        got  = {rx_write, frame_err, overrun, rx_data};
        want = {3'b000, m_data};
        if (!reset_n) begin
            m_data = '0;
            want   = '0;
        end else begin
            while (q.size() > 0 && cyc > q[0].cyc + 1) begin
                checks++;
                errors++;
                $display("FAIL missing_event: expected near cycle %0d, none by %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if ((rx_write || frame_err) && q.size() > 0 && cyc >= q[0].cyc - 1) begin
                e = q.pop_front();
                if (e.wr) m_data = e.data;
                want = {e.wr, !e.wr, e.wr && e.ovr, m_data};
            end
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL outputs cyc %0d: got wr=%b ferr=%b ovr=%b data=%h, want wr=%b ferr=%b ovr=%b data=%h",
                     cyc, got[9], got[8], got[7], got[6:0], want[9], want[8], want[7], want[6:0]);
        end
        if (rx_write) begin
            n_write++;
            prev_wr_cyc  = last_wr_cyc;
            prev_wr_data = last_wr_data;
            last_wr_cyc  = cyc;
            last_wr_data = rx_data;
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic flip);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.wr   = stop && !flip;
        e.data = b[6:0];
        e.ovr  = buf_full;
        q.push_back(e);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(b[i], 16);
`ifdef KB_UART_RX_PARITY_EN
        hold((^b) ^ flip, 16);
`endif
        hold(stop, 16);
    endtask

    initial begin
        int         t;
        int         w0;
        int         f0;
        int         o0;
        logic [7:0] b;
        reset_n  = 1'b0;
        rx       = 1'b1;
        buf_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({rx_write, frame_err, overrun, rx_busy, rx_data}), 0, 0);
        reset_n = 1'b1;
        hold(1'b1, 5);
        chk("idle_busy", int'(rx_busy), 0, 0);

        t = cyc;
        send(8'h41, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("t1_strobes", n_write, 1, 1);
        chk("t1_latency", last_wr_cyc - t, LAT_LIT - 1, LAT_LIT + 1);
        chk("t1_data", int'(rx_data), 'h41, 'h41);
        chk("t1_no_ferr", n_ferr, 0, 0);
        chk("t1_busy_low", int'(rx_busy), 0, 0);

        w0 = n_write;
        send(8'hC1, 1'b1, 1'b0);
        send(8'h7A, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("b2b_strobes", n_write - w0, 2, 2);
        chk("b2b_first_data", int'(prev_wr_data), 'h41, 'h41);
        chk("b2b_second_data", int'(rx_data), 'h7A, 'h7A);
        chk("b2b_gap", last_wr_cyc - prev_wr_cyc, GAP_LIT, GAP_LIT);

        w0 = n_write;
        f0 = n_ferr;
        hold(1'b0, 4);
        rx = 1'b1;
        for (int i = 0; i < 10 && rx_busy; i++) hold(1'b1, 1);
        chk("glitch_busy_low", int'(rx_busy), 0, 0);
        hold(1'b1, 20);
        chk("glitch_no_strobe", n_write - w0, 0, 0);
        chk("glitch_no_ferr", n_ferr - f0, 0, 0);

        send(8'h55, 1'b0, 1'b0);
        hold(1'b0, 40);
        chk("break_busy_high", int'(rx_busy), 1, 1);
        chk("break_one_ferr", n_ferr - f0, 1, 1);
        chk("break_no_strobe", n_write - w0, 0, 0);
        hold(1'b1, 4);
        chk("break_exit_busy", int'(rx_busy), 0, 0);
        send(8'h31, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("after_break_data", int'(rx_data), 'h31, 'h31);
        chk("after_break_strobe", n_write - w0, 1, 1);

        o0 = n_ovr;
        buf_full = 1'b1;
        send(8'h62, 1'b1, 1'b0);
        hold(1'b1, 20);
        buf_full = 1'b0;
        chk("ovr_pulse", n_ovr - o0, 1, 1);
        chk("ovr_data", int'(rx_data), 'h62, 'h62);

        b = 8'h41;
        w0 = n_write;
        hold(1'b0, 16);
        for (int i = 0; i < 3; i++) hold(b[i], 16);
        hold(b[3], 8);
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", int'({rx_write, frame_err, overrun, rx_busy, rx_data}), 0, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold(1'b1, 5);
        send(8'h42, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("midreset_one_strobe", n_write - w0, 1, 1);
        chk("midreset_data", int'(rx_data), 'h42, 'h42);

`ifdef KB_UART_RX_PARITY_EN
        w0 = n_write;
        f0 = n_ferr;
        send(8'h41, 1'b1, 1'b1);
        hold(1'b1, 20);
        chk("parity_no_strobe", n_write - w0, 0, 0);
        chk("parity_ferr", n_ferr - f0, 1, 1);
        chk("parity_data_held", int'(rx_data), 'h42, 'h42);
`endif

        hold(1'b1, 10);
        chk("model_drained", q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
